// File: rtl/serial_frame_receiver_if.sv
// Serial strobe inputs and parallel valid/ready word port of serial_frame_receiver.
// master drives the strobes and consumes words; slave is the receiver itself.
interface serial_frame_receiver_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             bit_en;
    logic             serial_in;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ready;
    logic             busy;
    logic             overrun;
    logic             clr_ovr;
    logic             parity_err;

    modport master (
        output start, bit_en, serial_in, data_ready, clr_ovr,
        input  data_out, data_valid, busy, overrun, parity_err
    );

    modport slave (
        input  start, bit_en, serial_in, data_ready, clr_ovr,
        output data_out, data_valid, busy, overrun, parity_err
    );
endinterface

// File: rtl/serial_frame_receiver.sv
// Rebuilds LSB-first serial words into a registered parallel port with valid/ready and overrun flag.
// Optional even-parity bit after the data bits: define SERIAL_FRAME_RECEIVER_PARITY_EN.
//
// state | meaning
// IDLE  | no frame in progress, waiting for start
// RECV  | collecting data bits, one per bit_en
// PAR   | waiting for the parity bit (parity build only)
module serial_frame_receiver #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_frame_receiver_if.slave frm_if
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, PAR = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1} state_t;
`endif

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             busy_q;
    logic             ovr_q;
    logic             perr_q;

    logic [WIDTH-1:0] shift_d;
    logic [WIDTH-1:0] word_d;
    logic             perr_d;
    logic             xfer_d;

    // Shifting the concatenation keeps every shreg bit in the expression for any WIDTH >= 2.
    always_comb begin
        shift_d = WIDTH'({frm_if.serial_in, shreg_q} >> 1);
        word_d  = shift_d;
        perr_d  = 1'b0;
        xfer_d  = 1'b0;
        if (!frm_if.start && frm_if.bit_en) begin
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
            if (state_q == PAR) begin
                word_d = shreg_q;
                perr_d = ^{shreg_q, frm_if.serial_in};
                xfer_d = 1'b1;
            end
`else
            if (state_q == RECV && count_q == LAST_BIT) begin
                xfer_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            if (frm_if.clr_ovr) begin
                ovr_q <= 1'b0;
            end
            if (valid_q && frm_if.data_ready) begin
                valid_q <= 1'b0;
            end
            // An unconsumed word is never overwritten; the new one is dropped instead.
            if (xfer_d) begin
                if (valid_q && !frm_if.data_ready) begin
                    ovr_q <= 1'b1;
                end else begin
                    data_q  <= word_d;
                    valid_q <= 1'b1;
                    perr_q  <= perr_d;
                end
            end

            case (state_q)
                IDLE: begin
                    if (frm_if.start) begin
                        state_q <= RECV;
                        count_q <= '0;
                        shreg_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                RECV: begin
                    if (frm_if.start) begin
                        count_q <= '0;
                        shreg_q <= '0;
                    end else if (frm_if.bit_en) begin
                        shreg_q <= shift_d;
                        count_q <= count_q + CW'(1);
                        if (count_q == LAST_BIT) begin
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
                            state_q <= PAR;
`else
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
`endif
                        end
                    end
                end
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
                PAR: begin
                    if (frm_if.start) begin
                        state_q <= RECV;
                        count_q <= '0;
                        shreg_q <= '0;
                    end else if (frm_if.bit_en) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign frm_if.data_out   = data_q;
    assign frm_if.data_valid = valid_q;
    assign frm_if.busy       = busy_q;
    assign frm_if.overrun    = ovr_q;
    assign frm_if.parity_err = perr_q;
endmodule

// File: tb/tb_serial_frame_receiver.sv
// Self-checking bench for serial_frame_receiver: vector table plus hand sequences, scoreboard on accepted words.
module tb_serial_frame_receiver;
    localparam int WIDTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    typedef struct {
        logic [7:0] data;
        logic       perr;
    } exp_t;
    exp_t sb_q[$];

    // seq holds the serial bits in time order, first bit in the MSB
    typedef struct {
        logic [7:0] seq;
        int         gap;
        logic [7:0] exp_data;
    } vec_t;
    vec_t vecs[8];

    serial_frame_receiver_if #(.WIDTH(WIDTH)) frm_if ();

    serial_frame_receiver #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .frm_if (frm_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    task automatic check_reset(input string name);
        check(name, 32'({frm_if.data_out, frm_if.data_valid, frm_if.busy,
                         frm_if.overrun, frm_if.parity_err}), 32'd0);
    endtask

    // Scoreboard: every handshake seen mid-cycle completes on the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && frm_if.data_valid && frm_if.data_ready) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got word %02h, expected no word", frm_if.data_out);
            end else begin
                e = sb_q.pop_front();
                check("sb_data", 32'(frm_if.data_out), 32'(e.data));
                check("sb_perr", 32'(frm_if.parity_err), 32'(e.perr));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic send_bit(input logic b);
        frm_if.bit_en    = 1'b1;
        frm_if.serial_in = b;
        cyc();
        frm_if.bit_en    = 1'b0;
        frm_if.serial_in = 1'b0;
    endtask

    task automatic pulse_start();
        frm_if.start = 1'b1;
        cyc();
        frm_if.start = 1'b0;
    endtask

    // Data bits (plus the correct even-parity bit when enabled); rdy_last raises data_ready for the final strobe.
    task automatic send_data(input logic [7:0] seq, input int gap, input logic rdy_last);
        for (int i = 0; i < 8; i++) begin
            idle(i % (gap + 1));
`ifndef SERIAL_FRAME_RECEIVER_PARITY_EN
            if (i == 7 && rdy_last) frm_if.data_ready = 1'b1;
`endif
            send_bit(seq[7-i]);
        end
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
        if (rdy_last) frm_if.data_ready = 1'b1;
        send_bit(^seq);
`endif
    endtask

    task automatic send_frame(input logic [7:0] seq, input int gap, input logic rdy_last);
        pulse_start();
        send_data(seq, gap, rdy_last);
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hA5, 0, 8'hA5};
        vecs[1] = '{8'h3C, 3, 8'h3C};
        vecs[2] = '{8'h80, 1, 8'h01};
        vecs[3] = '{8'h13, 2, 8'hC8};
        vecs[4] = '{8'hF0, 0, 8'h0F};
        vecs[5] = '{8'h48, 3, 8'h12};
        vecs[6] = '{8'h00, 0, 8'h00};
        vecs[7] = '{8'hFF, 1, 8'hFF};

        frm_if.start      = 1'b0;
        frm_if.bit_en     = 1'b0;
        frm_if.serial_in  = 1'b0;
        frm_if.data_ready = 1'b1;
        frm_if.clr_ovr    = 1'b0;

        idle(3);
        @(negedge clk);
        check_reset("reset_values");
        rst_n = 1'b1;
        cyc();

        send_bit(1'b1);
        send_bit(1'b1);
        @(negedge clk);
        check("idle_bit_busy", 32'(frm_if.busy), 32'd0);
        check("idle_bit_valid", 32'(frm_if.data_valid), 32'd0);

        for (int v = 0; v < 8; v++) begin
            send_frame(vecs[v].seq, vecs[v].gap, 1'b0);
            sb_q.push_back('{data: vecs[v].exp_data, perr: 1'b0});
            @(negedge clk);
            check($sformatf("vec%0d_valid", v), 32'(frm_if.data_valid), 32'd1);
            check($sformatf("vec%0d_busy", v), 32'(frm_if.busy), 32'd0);
            cyc();
            @(negedge clk);
            check($sformatf("vec%0d_valid_drop", v), 32'(frm_if.data_valid), 32'd0);
        end

        // back-pressure: 0x11 held, 0x22 dropped
        cyc();
        frm_if.data_ready = 1'b0;
        send_frame(8'h88, 0, 1'b0);
        sb_q.push_back('{data: 8'h11, perr: 1'b0});
        send_frame(8'h44, 1, 1'b0);
        @(negedge clk);
        check("ovr_data_kept", 32'(frm_if.data_out), 32'h11);
        check("ovr_valid", 32'(frm_if.data_valid), 32'd1);
        check("ovr_flag", 32'(frm_if.overrun), 32'd1);
        cyc();
        frm_if.data_ready = 1'b1;
        cyc();
        @(negedge clk);
        check("ovr_valid_drop", 32'(frm_if.data_valid), 32'd0);
        check("ovr_sticky", 32'(frm_if.overrun), 32'd1);
        cyc();
        frm_if.clr_ovr = 1'b1;
        cyc();
        frm_if.clr_ovr = 1'b0;
        @(negedge clk);
        check("ovr_cleared", 32'(frm_if.overrun), 32'd0);

        // overrun set and clear on the same edge: set wins
        cyc();
        frm_if.data_ready = 1'b0;
        send_frame(8'hF0, 0, 1'b0);
        sb_q.push_back('{data: 8'h0F, perr: 1'b0});
        frm_if.clr_ovr = 1'b1;
        send_frame(8'h48, 0, 1'b0);
        frm_if.clr_ovr = 1'b0;
        @(negedge clk);
        check("setwins_ovr", 32'(frm_if.overrun), 32'd1);
        check("setwins_data", 32'(frm_if.data_out), 32'h0F);
        cyc();
        frm_if.clr_ovr = 1'b1;
        cyc();
        frm_if.clr_ovr = 1'b0;

        // accept and load on the same edge: valid stays high, no overrun
        send_frame(8'h48, 1, 1'b1);
        sb_q.push_back('{data: 8'h12, perr: 1'b0});
        @(negedge clk);
        check("swap_valid", 32'(frm_if.data_valid), 32'd1);
        check("swap_data", 32'(frm_if.data_out), 32'h12);
        check("swap_no_ovr", 32'(frm_if.overrun), 32'd0);
        cyc();
        @(negedge clk);
        check("swap_valid_drop", 32'(frm_if.data_valid), 32'd0);

        // abort after 5 bits, restart with a simultaneous bit_en that must be ignored
        cyc();
        pulse_start();
        repeat (5) send_bit(1'b1);
        @(negedge clk);
        check("abort_busy_mid", 32'(frm_if.busy), 32'd1);
        frm_if.start     = 1'b1;
        frm_if.bit_en    = 1'b1;
        frm_if.serial_in = 1'b1;
        cyc();
        frm_if.start     = 1'b0;
        frm_if.bit_en    = 1'b0;
        frm_if.serial_in = 1'b0;
        @(negedge clk);
        check("abort_busy_restart", 32'(frm_if.busy), 32'd1);
        check("abort_no_valid", 32'(frm_if.data_valid), 32'd0);
        send_data(8'h81, 0, 1'b0);
        sb_q.push_back('{data: 8'h81, perr: 1'b0});
        @(negedge clk);
        check("abort_valid", 32'(frm_if.data_valid), 32'd1);
        check("abort_busy_end", 32'(frm_if.busy), 32'd0);
        cyc();

        // reset mid-frame
        pulse_start();
        repeat (4) send_bit(1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset("midframe_reset");
        cyc();
        @(negedge clk);
        check_reset("midframe_reset_hold");
        rst_n = 1'b1;
        cyc();
        send_frame(8'h5A, 2, 1'b0);
        sb_q.push_back('{data: 8'h5A, perr: 1'b0});
        @(negedge clk);
        check("post_reset_valid", 32'(frm_if.data_valid), 32'd1);
        cyc();

`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
        for (int p = 0; p < 2; p++) begin
            logic [7:0] s;
            s = 8'hA5;
            pulse_start();
            for (int i = 0; i < 8; i++) send_bit(s[7-i]);
            @(negedge clk);
            check($sformatf("par%0d_no_early_valid", p), 32'(frm_if.data_valid), 32'd0);
            send_bit(p[0]);
            sb_q.push_back('{data: 8'hA5, perr: p[0]});
            @(negedge clk);
            check($sformatf("par%0d_valid", p), 32'(frm_if.data_valid), 32'd1);
            check($sformatf("par%0d_err", p), 32'(frm_if.parity_err), 32'(p));
            cyc();
        end
`endif

        idle(3);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
